// File: rtl/round_pkg.sv
// Shared encodings for the tank-match round sequencer and its consumers (color_mapper).
package round_pkg;

  typedef enum logic [2:0] {
    TITLE     = 3'd0,
    SELECT    = 3'd1,
    COUNTDOWN = 3'd2,
    PLAY      = 3'd3,
    HIT       = 3'd4,
    GAME_OVER = 3'd5
  } state_t;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_A    = 2'b01;
  localparam logic [1:0] WINNER_B    = 2'b10;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: registered history, pulse high in the cycle the input first reads 1.
module rise_detect (
  input  logic clk,
  input  logic d,
  output logic rise
);

  logic prev;

  // History tracks the input even through reset, so a level held across reset never fires.
  always_ff @(posedge clk) prev <= d;

  assign rise = d & ~prev;

endmodule

// File: rtl/round_controller.sv
// Tank-match sequencer: title, tank select, countdown, play, hit pause, game over.
module round_controller
  import round_pkg::*;
#(
  parameter int WIN_SCORE        = 3,
  parameter int COUNTDOWN_FRAMES = 180,
  parameter int HIT_HOLD_FRAMES  = 120,
  parameter int SCORE_W          = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               start,
  input  logic               select_done_A,
  input  logic               select_done_B,
  input  logic               hit_A,
  input  logic               hit_B,
  output logic [2:0]         currentState,
  output logic               play_enable,
  output logic               round_reset,
  output logic [7:0]         frames_left,
  output logic [SCORE_W-1:0] score_A,
  output logic [SCORE_W-1:0] score_B,
  output logic [1:0]         winner
);

  localparam int MAX_FRAMES = (COUNTDOWN_FRAMES > HIT_HOLD_FRAMES) ? COUNTDOWN_FRAMES : HIT_HOLD_FRAMES;
  localparam int TIMER_W    = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
  localparam logic [TIMER_W-1:0] CD_LOAD  = TIMER_W'(COUNTDOWN_FRAMES - 1);
  localparam logic [TIMER_W-1:0] HIT_LOAD = TIMER_W'(HIT_HOLD_FRAMES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);

  state_t               state, nxt_state;
  logic [TIMER_W-1:0]   timer, nxt_timer;
  logic [SCORE_W-1:0]   nxt_score_a, nxt_score_b, inc_a, inc_b;
  logic [1:0]           nxt_winner;
  logic                 sel_a, sel_b, nxt_sel_a, nxt_sel_b, nxt_round_reset;
  logic                 start_rise, hit_a_rise, hit_b_rise;

  rise_detect u_start (.clk(Clk), .d(start), .rise(start_rise));
  rise_detect u_hit_a (.clk(Clk), .d(hit_A), .rise(hit_a_rise));
  rise_detect u_hit_b (.clk(Clk), .d(hit_B), .rise(hit_b_rise));

  assign inc_a = (score_A == SCORE_MAX) ? score_A : score_A + SCORE_W'(1);
  assign inc_b = (score_B == SCORE_MAX) ? score_B : score_B + SCORE_W'(1);

  always_comb begin
    nxt_state       = state;
    nxt_timer       = timer;
    nxt_score_a     = score_A;
    nxt_score_b     = score_B;
    nxt_winner      = winner;
    nxt_sel_a       = sel_a;
    nxt_sel_b       = sel_b;
    nxt_round_reset = 1'b0;
    case (state)
      TITLE: if (start_rise) begin
        nxt_state   = SELECT;
        nxt_score_a = '0;
        nxt_score_b = '0;
        nxt_winner  = WINNER_NONE;
        nxt_sel_a   = 1'b0;
        nxt_sel_b   = 1'b0;
      end
      SELECT: begin
        nxt_sel_a = sel_a | select_done_A;
        nxt_sel_b = sel_b | select_done_B;
        if (nxt_sel_a && nxt_sel_b) begin
          nxt_state       = COUNTDOWN;
          nxt_timer       = CD_LOAD;
          nxt_round_reset = 1'b1;
          nxt_sel_a       = 1'b0;
          nxt_sel_b       = 1'b0;
        end
      end
      COUNTDOWN: begin
        if (timer == '0) nxt_state = PLAY;
        else             nxt_timer = timer - TIMER_W'(1);
      end
      PLAY: begin
        if (hit_a_rise && hit_b_rise) begin
          nxt_state = HIT;
          nxt_timer = HIT_LOAD;
        end else if (hit_b_rise) begin
          nxt_score_a = inc_a;
          if (inc_a == WIN_VAL) begin
            nxt_state  = GAME_OVER;
            nxt_winner = WINNER_A;
          end else begin
            nxt_state = HIT;
            nxt_timer = HIT_LOAD;
          end
        end else if (hit_a_rise) begin
          nxt_score_b = inc_b;
          if (inc_b == WIN_VAL) begin
            nxt_state  = GAME_OVER;
            nxt_winner = WINNER_B;
          end else begin
            nxt_state = HIT;
            nxt_timer = HIT_LOAD;
          end
        end
      end
      HIT: begin
        if (timer == '0) begin
          nxt_state       = COUNTDOWN;
          nxt_timer       = CD_LOAD;
          nxt_round_reset = 1'b1;
        end else begin
          nxt_timer = timer - TIMER_W'(1);
        end
      end
      GAME_OVER: if (start_rise) begin
        nxt_state   = TITLE;
        nxt_score_a = '0;
        nxt_score_b = '0;
        nxt_winner  = WINNER_NONE;
      end
      default: nxt_state = TITLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= TITLE;
      timer       <= '0;
      score_A     <= '0;
      score_B     <= '0;
      winner      <= WINNER_NONE;
      sel_a       <= 1'b0;
      sel_b       <= 1'b0;
      round_reset <= 1'b0;
    end else begin
      state       <= nxt_state;
      timer       <= nxt_timer;
      score_A     <= nxt_score_a;
      score_B     <= nxt_score_b;
      winner      <= nxt_winner;
      sel_a       <= nxt_sel_a;
      sel_b       <= nxt_sel_b;
      round_reset <= nxt_round_reset;
    end
  end

  assign currentState = state;
  assign play_enable  = (state == PLAY);

  // Timer contents are stale outside COUNTDOWN/HIT, so the display is forced to 0 there.
  always_comb begin
    frames_left = '0;
    if (state == COUNTDOWN || state == HIT)
      frames_left = (32'(timer) > 255) ? 8'hFF : 8'(timer);
  end

endmodule

// File: tb/tb_round_controller.sv
// Random-stimulus bench for round_controller against a behavioural match model.
module tb_round_controller;

  localparam int WIN = 3;
  localparam int CD  = 180;
  localparam int HH  = 120;
  localparam int SW  = 4;
  localparam int SMAX = (1 << SW) - 1;

  logic Clk = 1'b0;
  logic Reset = 1'b1, start = 1'b0, sel_a = 1'b0, sel_b = 1'b0, hit_a = 1'b0, hit_b = 1'b0;
  logic [2:0]    cur_state;
  logic          play_en, rnd_rst;
  logic [7:0]    frames;
  logic [SW-1:0] sc_a, sc_b;
  logic [1:0]    win;

  round_controller #(
    .WIN_SCORE(WIN), .COUNTDOWN_FRAMES(CD), .HIT_HOLD_FRAMES(HH), .SCORE_W(SW)
  ) dut (
    .Clk(Clk), .Reset(Reset), .start(start),
    .select_done_A(sel_a), .select_done_B(sel_b), .hit_A(hit_a), .hit_B(hit_b),
    .currentState(cur_state), .play_enable(play_en), .round_reset(rnd_rst),
    .frames_left(frames), .score_A(sc_a), .score_B(sc_b), .winner(win)
  );

  always #5 Clk = ~Clk;

  // Model of the match: phase numbers follow the published state encoding.
  int m_ph, m_tmr, m_sa, m_sb, m_win, m_rr;
  bit m_la, m_lb, p_start, p_ha, p_hb;
  int n_chk, n_fail, cyc, go_seen, draw_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 25)
        $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_step();
    bit rs, rha, rhb;
    rs  = start && !p_start;
    rha = hit_a && !p_ha;
    rhb = hit_b && !p_hb;
    p_start = start; p_ha = hit_a; p_hb = hit_b;
    m_rr = 0;
    if (Reset) begin
      m_ph = 0; m_tmr = 0; m_sa = 0; m_sb = 0; m_win = 0; m_la = 0; m_lb = 0;
      return;
    end
    case (m_ph)
      0: if (rs) begin m_ph = 1; m_sa = 0; m_sb = 0; m_win = 0; m_la = 0; m_lb = 0; end
      1: begin
        m_la = m_la | sel_a;
        m_lb = m_lb | sel_b;
        if (m_la && m_lb) begin m_ph = 2; m_tmr = CD - 1; m_rr = 1; m_la = 0; m_lb = 0; end
      end
      2: if (m_tmr == 0) m_ph = 3; else m_tmr--;
      3: begin
        if (rha && rhb) begin
          m_ph = 4; m_tmr = HH - 1; draw_seen++;
        end else if (rhb || rha) begin
          if (rhb) m_sa = (m_sa < SMAX) ? m_sa + 1 : m_sa;
          else     m_sb = (m_sb < SMAX) ? m_sb + 1 : m_sb;
          if ((rhb ? m_sa : m_sb) == WIN) begin
            m_ph = 5; m_win = rhb ? 1 : 2; go_seen++;
          end else begin
            m_ph = 4; m_tmr = HH - 1;
          end
        end
      end
      4: if (m_tmr == 0) begin m_ph = 2; m_tmr = CD - 1; m_rr = 1; end else m_tmr--;
      5: if (rs) begin m_ph = 0; m_sa = 0; m_sb = 0; m_win = 0; end
      default: m_ph = 0;
    endcase
  endtask

  task automatic step();
    int exp_frames;
    @(posedge Clk);
    model_step();
    #1;
    exp_frames = (m_ph == 2 || m_ph == 4) ? ((m_tmr > 255) ? 255 : m_tmr) : 0;
    chk("state",       32'(cur_state), 32'(m_ph));
    chk("play_enable", 32'(play_en),   32'(m_ph == 3));
    chk("round_reset", 32'(rnd_rst),   32'(m_rr));
    chk("frames_left", 32'(frames),    32'(exp_frames));
    chk("score_A",     32'(sc_a),      32'(m_sa));
    chk("score_B",     32'(sc_b),      32'(m_sb));
    chk("winner",      32'(win),       32'(m_win));
    cyc++;
  endtask

  initial begin
    // Reset with start held through release: must stay in TITLE.
    Reset = 1'b1; start = 1'b1;
    repeat (3) step();
    Reset = 1'b0;
    repeat (3) step();
    // Start pulse, then staggered tank confirmations.
    start = 1'b0; step();
    start = 1'b1; step();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      sel_a = (i == 3);
      sel_b = (i == 7);
      step();
    end
    sel_a = 1'b0; sel_b = 1'b0;
    // Random play, with rare resets landing in any phase.
    for (int i = 0; i < 30000; i++) begin
      int r;
      Reset = ($urandom_range(0, 2999) == 0);
      if ($urandom_range(0, 29) == 0) start = ~start;
      sel_a = ($urandom_range(0, 19) == 0);
      sel_b = ($urandom_range(0, 19) == 0);
      r = $urandom_range(0, 99);
      if (r < 2)       hit_a = ~hit_a;
      else if (r < 4)  hit_b = ~hit_b;
      else if (r == 4) begin hit_a = 1'b1; hit_b = 1'b1; end
      else if (r == 5) begin hit_a = 1'b0; hit_b = 1'b0; end
      step();
    end
    $display("coverage: game_over=%0d draws=%0d", go_seen, draw_seen);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
